// File: rtl/reg_file_sb.sv
// Multi-read-port register file with per-register pending (scoreboard) bits; entry 0 is hardwired zero.
// Optional write-through read bypass is enabled by defining REGFILE_BYPASS_EN.
module reg_file_sb #(
  parameter  int DATA_WIDTH = 32,
  parameter  int NUM_REGS   = 32,
  parameter  int NUM_RD     = 2,
  localparam int ADDR_W     = $clog2(NUM_REGS),
  localparam int CNT_W      = $clog2(NUM_REGS) + 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic                         alloc_en,
  input  logic [ADDR_W-1:0]            alloc_addr,
  input  logic                         flush,
  input  logic [NUM_RD*ADDR_W-1:0]     rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]            rd_busy,
  output logic [CNT_W-1:0]             busy_cnt
);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]   pend;
  logic [NUM_REGS-1:0]   pend_nxt;
  logic                  wr_hit;
  logic                  alloc_hit;

  assign wr_hit    = wr_en && (wr_addr != '0);
  assign alloc_hit = alloc_en && (alloc_addr != '0);

  // Later assignments win: flush < write-clear < alloc, so the newest producer keeps its bit.
  always_comb begin
    pend_nxt = pend;
    if (flush)     pend_nxt = '0;
    if (wr_hit)    pend_nxt[wr_addr] = 1'b0;
    if (alloc_hit) pend_nxt[alloc_addr] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[ADDR_W'(i)] <= '0;
      pend     <= '0;
      busy_cnt <= '0;
    end else begin
      if (wr_hit) regs[wr_addr] <= wr_data;
      pend     <= pend_nxt;
      busy_cnt <= CNT_W'($countones(pend_nxt));
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0]     ra;
    logic [DATA_WIDTH-1:0] data;
    logic                  busy;

    assign ra = rd_addr[p*ADDR_W +: ADDR_W];

    always_comb begin
      data = (ra == '0) ? '0 : regs[ra];
      busy = (ra == '0) ? 1'b0 : pend[ra];
`ifdef REGFILE_BYPASS_EN
      // A same-cycle allocation of the written register re-marks it busy; data still forwards.
      if (wr_hit && (wr_addr == ra)) begin
        data = wr_data;
        busy = alloc_hit && (alloc_addr == wr_addr);
      end
`endif
    end

    assign rd_data[p*DATA_WIDTH +: DATA_WIDTH] = data;
    assign rd_busy[p]                          = busy;
  end

endmodule
